// File: rtl/ctr_player.sv
// rtl/ctr_player.sv - stimulus driver and independent scoreboard for the counter game block
module ctr_player #(
  parameter int         COUNTER_SIZE = 3,
  parameter int         SCORE_LIMIT  = 15,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [1:0]              fixed_control,
  input  logic [COUNTER_SIZE-1:0] seed_value,
  input  logic                    WINNER,
  input  logic                    LOSER,
  input  logic                    GAMEOVER,
  input  logic [1:0]              WHO,
  output logic [1:0]              control,
  output logic                    INIT,
  output logic [COUNTER_SIZE-1:0] initial_value,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              result,
  output logic [3:0]              win_count,
  output logic [3:0]              lose_count,
  output logic                    mismatch
);

  localparam logic [3:0] LIMIT = 4'(SCORE_LIMIT);

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, WAIT, REPORT} state_t;

  state_t                  state, state_d;
  logic [1:0]              mode_q, mode_d, fc_q, fc_d, control_d, result_d, expected;
  logic                    init_d, busy_d, done_d, mis_d, dir, dir_d, hit, hit_d;
  logic [COUNTER_SIZE-1:0] iv_d;
  logic [3:0]              win_d, lose_d;
  logic [7:0]              lfsr, lfsr_d;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= LIMIT) ? v : v + 4'd1;
  endfunction

  always_comb begin
    state_d   = state;
    mode_d    = mode_q;
    fc_d      = fc_q;
    control_d = 2'b00;
    init_d    = 1'b0;
    iv_d      = initial_value;
    done_d    = 1'b0;
    result_d  = result;
    win_d     = win_count;
    lose_d    = lose_count;
    mis_d     = mismatch;
    lfsr_d    = lfsr;
    dir_d     = dir;
    hit_d     = hit;
    expected  = 2'b00;
    case (state)
      IDLE: begin
        if (start) begin
          mode_d   = mode;
          fc_d     = fixed_control;
          iv_d     = seed_value;
          win_d    = 4'd0;
          lose_d   = 4'd0;
          result_d = 2'b00;
          mis_d    = 1'b0;
          hit_d    = 1'b0;
          init_d   = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        dir_d   = 1'b0;
        state_d = PLAY;
      end
      PLAY: begin
        // A simultaneous WINNER/LOSER counts as a loss and is flagged
        if (LOSER) begin
          lose_d = sat_inc(lose_count);
          dir_d  = 1'b0;
          if (WINNER) mis_d = 1'b1;
        end else if (WINNER) begin
          win_d = sat_inc(win_count);
          dir_d = 1'b1;
        end
        if (GAMEOVER) begin
          if (lose_d == LIMIT)     expected = 2'b01;
          else if (win_d == LIMIT) expected = 2'b10;
          result_d = WHO;
          if (WHO != expected) mis_d = 1'b1;
          state_d = WAIT;
        end else if (lose_count == LIMIT || win_count == LIMIT) begin
          // Second consecutive cycle at the limit without GAMEOVER: give up
          if (hit) begin
            mis_d    = 1'b1;
            result_d = 2'b00;
            state_d  = WAIT;
          end else begin
            hit_d = 1'b1;
          end
        end
      end
      WAIT: begin
        done_d  = 1'b1;
        state_d = REPORT;
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == PLAY) begin
      lfsr_d = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      case (mode_d)
        2'b01:   control_d = lfsr_d[1:0];
        2'b10:   control_d = {dir_d, fc_d[0]};
        default: control_d = fc_d;
      endcase
    end
    busy_d = (state_d != IDLE) && (state_d != REPORT);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      mode_q        <= 2'b00;
      fc_q          <= 2'b00;
      control       <= 2'b00;
      INIT          <= 1'b0;
      initial_value <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      result        <= 2'b00;
      win_count     <= 4'd0;
      lose_count    <= 4'd0;
      mismatch      <= 1'b0;
      lfsr          <= LFSR_SEED;
      dir           <= 1'b0;
      hit           <= 1'b0;
    end else begin
      state         <= state_d;
      mode_q        <= mode_d;
      fc_q          <= fc_d;
      control       <= control_d;
      INIT          <= init_d;
      initial_value <= iv_d;
      busy          <= busy_d;
      done          <= done_d;
      result        <= result_d;
      win_count     <= win_d;
      lose_count    <= lose_d;
      mismatch      <= mis_d;
      lfsr          <= lfsr_d;
      dir           <= dir_d;
      hit           <= hit_d;
    end
  end

endmodule
